battleship_engine: RTL
======================

Name: battleship_engine

Overview:
Parametrised successor of the fixed 5x5 Battleship game core. Holds both NxN boards, sequences player/PC turns with a per-turn countdown, and generates PC shots from an LFSR that skips cells already fired on. Tracks remaining ship cells per side and declares win/lose. Sits between the button/coordinate selectors, the seconds divider and the VGA/seven-segment outputs.

Parameters:
BOARD_N, 5, board edge length (2..16)
TURN_SECS, 12, seconds allowed per player turn
LFSR_SEED, 16'hACE1, non-zero reset seed of the 16-bit PC-shot LFSR
RW (derived), $clog2(BOARD_N), coordinate width
CW (derived), $clog2(BOARD_N*BOARD_N+1), ship-cell counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, IDLE -> PLAY
tick  in  1  one-cycle 1 Hz strobe from the seconds divider
fire  in  1  one-cycle pulse, player shoots at sel_row/sel_col
sel_row, sel_col  in  RW  player target
cfg_we  in  1  place one ship cell (IDLE only)
cfg_board  in  1  0 = player board, 1 = PC board
cfg_row, cfg_col  in  RW  placement coordinate
rd_board  in  1  board select for the display read port
rd_row, rd_col  in  RW  display read coordinate
rd_cell  out  2  cell code, registered
state  out  3  current FSM state code
player_left, pc_left  out  CW  unhit ship cells per side
secs_left  out  $clog2(TURN_SECS+1)  turn countdown
shot_valid  out  1  one-cycle pulse per accepted shot
shot_pc, shot_hit  out  1  shooter (1 = PC), result
shot_row, shot_col  out  RW  coordinate of the accepted shot
reject  out  1  one-cycle pulse: fire refused

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: boards all EMPTY; counts 0; state IDLE; secs_left 0; LFSR = LFSR_SEED; all pulses 0; rd_cell 0.
- Cell codes: 0 EMPTY, 1 SHIP, 2 HIT, 3 MISS.
- IDLE: a cfg_we on an EMPTY in-range cell writes SHIP and increments that side's count. Writes to a SHIP cell or an out-of-range cell are ignored. start moves to PLAY only when both counts are nonzero; otherwise start is ignored.
- PLAY: on entry secs_left = TURN_SECS.
  - tick decrements secs_left. A tick while secs_left==1 drives it to 0 and moves to PC_SEL (turn forfeited).
  - fire on an in-range, unshot PC cell marks it HIT or MISS. The shot pulses appear the next cycle. A HIT decrements pc_left.
  - After the shot: if pc_left reaches 0, go to WIN; else go to PC_SEL.
  - fire on an out-of-range or already-shot cell pulses reject, with no state change.
  - fire and the expiring tick in the same cycle: fire wins and the timer is ignored.
- PC_SEL: idx = LFSR[15:0] mod (N*N), captured on entry. The LFSR advances every cycle in every state.
- PC_SCAN: if the player cell at idx is EMPTY or SHIP, fire on it (HIT decrements player_left) and pulse shot_valid with shot_pc=1. Otherwise idx = idx+1, wrapping to 0 after N*N-1. Scanning takes at most N*N cycles.
- After a PC shot: if player_left reaches 0, go to LOSE; else go to PLAY.
- WIN and LOSE hold until rst. start, fire and cfg_we are ignored there.
- Simultaneous cfg_we and start in IDLE: the write is applied, and the start check uses the pre-write counts.
- Read port: rd_cell is valid 1 cycle after the rd_* inputs, in all states. An out-of-range read returns 0.
- state codes: IDLE 0, PLAY 1, PC_SEL 2, PC_SCAN 3, WIN 4, LOSE 5.

Decomposition:
- Package battleship_pkg: cell_t enum (EMPTY/SHIP/HIT/MISS), state_t enum, state code constants.
- One sub-module, pc_shot_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) with a synchronous reset to seed. The mod/scan logic stays in the parent.

Test Plan:
- Placement/start: place 2 player and 3 PC cells, then start -> state=1, player_left=2, pc_left=3, secs_left=12. A start with pc_left=0 -> state stays 0.
- Player hit then PC shot: fire at a PC ship cell -> next cycle shot_valid=1, shot_pc=0, shot_hit=1, pc_left decrements by 1. Within N*N+2 cycles a PC shot_valid arrives and state returns to 1.
- Duplicate/out-of-range fire: refire the same cell, then fire with row=5 when N=5 -> reject pulses each time, no state change.
- Timeout: 12 ticks with no fire -> state goes to PC_SEL after the 12th tick. 11 ticks then fire coincident with the 12th tick -> player shot accepted.
- Win/lose: sink the last PC cell -> state=4, and further fire/start is ignored. Symmetric: the PC sinks the last player cell -> state=5.
- Full scan / reset: all player cells except one already shot -> the PC hits the remaining cell. rst asserted mid-PC_SCAN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared types for the Battleship engine: cell codes, FSM state codes and a
// small helper classifying cells that can still be fired on.
package battleship_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SHIP  = 2'd1,
    CELL_HIT   = 2'd2,
    CELL_MISS  = 2'd3
  } cell_t;

  localparam logic [2:0] STATE_CODE_IDLE    = 3'd0;
  localparam logic [2:0] STATE_CODE_PLAY    = 3'd1;
  localparam logic [2:0] STATE_CODE_PC_SEL  = 3'd2;
  localparam logic [2:0] STATE_CODE_PC_SCAN = 3'd3;
  localparam logic [2:0] STATE_CODE_WIN     = 3'd4;
  localparam logic [2:0] STATE_CODE_LOSE    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = STATE_CODE_IDLE,
    ST_PLAY    = STATE_CODE_PLAY,
    ST_PC_SEL  = STATE_CODE_PC_SEL,
    ST_PC_SCAN = STATE_CODE_PC_SCAN,
    ST_WIN     = STATE_CODE_WIN,
    ST_LOSE    = STATE_CODE_LOSE
  } state_t;

  // A cell that has not been fired on yet (water or intact ship).
  function automatic logic is_unshot(input cell_t c);
    return (c == CELL_EMPTY) || (c == CELL_SHIP);
  endfunction

endpackage

// File: rtl/battleship_engine_pc_shot_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that free-runs every cycle and
// supplies the raw PC target; the parent reduces it onto the board.
module pc_shot_lfsr
  import battleship_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  logic [15:0] lfsr_r;
  logic        feedback_s;

  assign feedback_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  assign value      = lfsr_r;

  // Shift register: reload seed on reset, otherwise advance every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], feedback_s};
    end
  end

endmodule

// File: rtl/battleship_engine.sv
// Battleship game core: two NxN boards, player/PC turn sequencing with a
// per-turn countdown, LFSR-driven PC targeting that skips already-shot cells,
// ship-cell bookkeeping and win/lose detection.
module battleship_engine
  import battleship_pkg::*;
#(
  parameter int          BOARD_N   = 5,
  parameter int          TURN_SECS = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         RW        = $clog2(BOARD_N),
  localparam int         CW        = $clog2(BOARD_N*BOARD_N+1),
  localparam int         SW        = $clog2(TURN_SECS+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          tick,
  input  logic          fire,
  input  logic [RW-1:0] sel_row,
  input  logic [RW-1:0] sel_col,
  input  logic          cfg_we,
  input  logic          cfg_board,
  input  logic [RW-1:0] cfg_row,
  input  logic [RW-1:0] cfg_col,
  input  logic          rd_board,
  input  logic [RW-1:0] rd_row,
  input  logic [RW-1:0] rd_col,
  output logic [1:0]    rd_cell,
  output logic [2:0]    state,
  output logic [CW-1:0] player_left,
  output logic [CW-1:0] pc_left,
  output logic [SW-1:0] secs_left,
  output logic          shot_valid,
  output logic          shot_pc,
  output logic          shot_hit,
  output logic [RW-1:0] shot_row,
  output logic [RW-1:0] shot_col,
  output logic          reject
);

  localparam int            NN         = BOARD_N * BOARD_N;
  localparam int            IW         = $clog2(NN);
  localparam logic [IW-1:0] N_IW       = IW'(BOARD_N);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NN - 1);
  localparam logic [IW-1:0] IDX_ZERO   = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [15:0]   NN_16      = 16'(NN);
  localparam logic [RW:0]   N_EXT      = (RW+1)'(BOARD_N);
  localparam logic [SW-1:0] SECS_INIT  = SW'(TURN_SECS);
  localparam logic [SW-1:0] SECS_ONE   = SW'(1);
  localparam logic [SW-1:0] SECS_ZERO  = {SW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};

  // Coordinate lies on the board (RW may cover more than BOARD_N values).
  function automatic logic in_range(input logic [RW-1:0] r, input logic [RW-1:0] c);
    return ({1'b0, r} < N_EXT) && ({1'b0, c} < N_EXT);
  endfunction

  // Row-major flat cell index.
  function automatic logic [IW-1:0] flat(input logic [RW-1:0] r, input logic [RW-1:0] c);
    return IW'(r) * N_IW + IW'(c);
  endfunction

  state_t        state_r, state_nxt_s;
  cell_t         player_board_r [NN];
  cell_t         pc_board_r     [NN];
  logic [CW-1:0] player_left_r, pc_left_r;
  logic [SW-1:0] secs_left_r;
  logic [IW-1:0] idx_r;
  logic [1:0]    rd_cell_r;
  logic          shot_valid_r, shot_pc_r, shot_hit_r, reject_r;
  logic [RW-1:0] shot_row_r, shot_col_r;

  logic [15:0]   lfsr_s;
  logic [IW-1:0] lfsr_mod_s, idx_next_s;
  logic [IW-1:0] cfg_idx_s, sel_idx_s, rd_idx_s;
  logic          cfg_ok_s, sel_ok_s, rd_ok_s;
  cell_t         cfg_cell_s, sel_cell_s, scan_cell_s, rd_src_s;
  logic [RW-1:0] scan_row_s, scan_col_s;
  logic          player_hit_s, pc_hit_s;
  logic          cfg_wr_s, player_shot_s, pc_shot_s, reject_s;
  logic          secs_load_s, secs_dec_s, idx_load_s, idx_inc_s;

  pc_shot_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_s)
  );

  // Coordinates are forced to cell 0 when off-board so no array read leaves
  // the board; the *_ok_s flags keep such accesses from having any effect.
  assign cfg_ok_s     = in_range(cfg_row, cfg_col);
  assign sel_ok_s     = in_range(sel_row, sel_col);
  assign rd_ok_s      = in_range(rd_row, rd_col);
  assign cfg_idx_s    = cfg_ok_s ? flat(cfg_row, cfg_col) : IDX_ZERO;
  assign sel_idx_s    = sel_ok_s ? flat(sel_row, sel_col) : IDX_ZERO;
  assign rd_idx_s     = rd_ok_s  ? flat(rd_row, rd_col)   : IDX_ZERO;
  assign cfg_cell_s   = cfg_board ? pc_board_r[cfg_idx_s] : player_board_r[cfg_idx_s];
  assign sel_cell_s   = pc_board_r[sel_idx_s];
  assign scan_cell_s  = player_board_r[idx_r];
  assign rd_src_s     = rd_board ? pc_board_r[rd_idx_s] : player_board_r[rd_idx_s];
  assign player_hit_s = (sel_cell_s == CELL_SHIP);
  assign pc_hit_s     = (scan_cell_s == CELL_SHIP);
  assign lfsr_mod_s   = IW'(lfsr_s % NN_16);
  assign idx_next_s   = (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
  assign scan_row_s   = RW'(idx_r / N_IW);
  assign scan_col_s   = RW'(idx_r % N_IW);

  // Next-state and datapath control for the game sequencer.
  always_comb begin
    state_nxt_s   = state_r;
    cfg_wr_s      = 1'b0;
    player_shot_s = 1'b0;
    pc_shot_s     = 1'b0;
    reject_s      = 1'b0;
    secs_load_s   = 1'b0;
    secs_dec_s    = 1'b0;
    idx_load_s    = 1'b0;
    idx_inc_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cfg_wr_s = cfg_we && cfg_ok_s && (cfg_cell_s == CELL_EMPTY);
        // The start check deliberately uses the counts before any same-cycle write.
        if (start && (player_left_r != CNT_ZERO) && (pc_left_r != CNT_ZERO)) begin
          state_nxt_s = ST_PLAY;
          secs_load_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (fire && sel_ok_s && is_unshot(sel_cell_s)) begin
          // An accepted shot ends the turn and overrides a coincident tick.
          player_shot_s = 1'b1;
          if (player_hit_s && (pc_left_r == CNT_ONE)) begin
            state_nxt_s = ST_WIN;
          end else begin
            state_nxt_s = ST_PC_SEL;
          end
        end else begin
          reject_s = fire;
          if (tick && (secs_left_r != SECS_ZERO)) begin
            secs_dec_s = 1'b1;
            if (secs_left_r == SECS_ONE) begin
              state_nxt_s = ST_PC_SEL;
            end else begin
              state_nxt_s = ST_PLAY;
            end
          end else begin
            state_nxt_s = ST_PLAY;
          end
        end
      end
      ST_PC_SEL: begin
        idx_load_s  = 1'b1;
        state_nxt_s = ST_PC_SCAN;
      end
      ST_PC_SCAN: begin
        if (is_unshot(scan_cell_s)) begin
          pc_shot_s = 1'b1;
          if (pc_hit_s && (player_left_r == CNT_ONE)) begin
            state_nxt_s = ST_LOSE;
          end else begin
            state_nxt_s = ST_PLAY;
            secs_load_s = 1'b1;
          end
        end else begin
          idx_inc_s   = 1'b1;
          state_nxt_s = ST_PC_SCAN;
        end
      end
      ST_WIN:  state_nxt_s = ST_WIN;
      ST_LOSE: state_nxt_s = ST_LOSE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Board storage: ship placement in IDLE, shot marking during turns.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NN; i++) begin
        player_board_r[i] <= CELL_EMPTY;
        pc_board_r[i]     <= CELL_EMPTY;
      end
    end else begin
      if (cfg_wr_s && cfg_board) begin
        pc_board_r[cfg_idx_s] <= CELL_SHIP;
      end
      if (cfg_wr_s && !cfg_board) begin
        player_board_r[cfg_idx_s] <= CELL_SHIP;
      end
      if (player_shot_s) begin
        pc_board_r[sel_idx_s] <= player_hit_s ? CELL_HIT : CELL_MISS;
      end
      if (pc_shot_s) begin
        player_board_r[idx_r] <= pc_hit_s ? CELL_HIT : CELL_MISS;
      end
    end
  end

  // Remaining ship-cell counters per side.
  always_ff @(posedge clk) begin
    if (rst) begin
      player_left_r <= CNT_ZERO;
      pc_left_r     <= CNT_ZERO;
    end else begin
      if (cfg_wr_s && !cfg_board) begin
        player_left_r <= player_left_r + CNT_ONE;
      end else if (pc_shot_s && pc_hit_s) begin
        player_left_r <= player_left_r - CNT_ONE;
      end
      if (cfg_wr_s && cfg_board) begin
        pc_left_r <= pc_left_r + CNT_ONE;
      end else if (player_shot_s && player_hit_s) begin
        pc_left_r <= pc_left_r - CNT_ONE;
      end
    end
  end

  // Per-turn countdown, reloaded whenever a player turn begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      secs_left_r <= SECS_ZERO;
    end else if (secs_load_s) begin
      secs_left_r <= SECS_INIT;
    end else if (secs_dec_s) begin
      secs_left_r <= secs_left_r - SECS_ONE;
    end
  end

  // PC target index: captured from the LFSR, then walked past shot cells.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= IDX_ZERO;
    end else if (idx_load_s) begin
      idx_r <= lfsr_mod_s;
    end else if (idx_inc_s) begin
      idx_r <= idx_next_s;
    end
  end

  // Registered shot report and reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      shot_valid_r <= 1'b0;
      shot_pc_r    <= 1'b0;
      shot_hit_r   <= 1'b0;
      shot_row_r   <= {RW{1'b0}};
      shot_col_r   <= {RW{1'b0}};
      reject_r     <= 1'b0;
    end else begin
      shot_valid_r <= player_shot_s | pc_shot_s;
      reject_r     <= reject_s;
      if (player_shot_s) begin
        shot_pc_r  <= 1'b0;
        shot_hit_r <= player_hit_s;
        shot_row_r <= sel_row;
        shot_col_r <= sel_col;
      end else if (pc_shot_s) begin
        shot_pc_r  <= 1'b1;
        shot_hit_r <= pc_hit_s;
        shot_row_r <= scan_row_s;
        shot_col_r <= scan_col_s;
      end
    end
  end

  // Display read port, one cycle latency, zero when off-board.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cell_r <= 2'd0;
    end else begin
      rd_cell_r <= rd_ok_s ? rd_src_s : 2'd0;
    end
  end

  assign state       = state_r;
  assign player_left = player_left_r;
  assign pc_left     = pc_left_r;
  assign secs_left   = secs_left_r;
  assign shot_valid  = shot_valid_r;
  assign shot_pc     = shot_pc_r;
  assign shot_hit    = shot_hit_r;
  assign shot_row    = shot_row_r;
  assign shot_col    = shot_col_r;
  assign reject      = reject_r;
  assign rd_cell     = rd_cell_r;

endmodule
